alu_exec_stage: RTL and testbench

Parametrised execute stage replacing the single-op ADD-only ALU stage between decode (ID/EX) and writeback (EX/WB). It implements the full RV32I integer ALU operation set at width XLEN. Single-cycle ops finish in one cycle; shifts run on an iterative shifter that moves SHIFT_STEP bits per cycle. Valid/ready handshakes on both sides let writeback apply backpressure, and a flush input squashes in-flight work.

---
 rtl/alu_exec_stage.sv | 189 ++++++++++++++++++
 tb/tb_alu_exec_stage.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_exec_stage.sv
// alu_exec_stage: RV32I-style integer execute stage between decode and
// writeback. Single-cycle ops load the output register at the accept edge;
// shifts run on an iterative shifter moving up to SHIFT_STEP bits per cycle.
// Valid/ready on both sides, synchronous flush, asynchronous reset.
module alu_exec_stage #(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned REG_ADDR_W = 5,
  parameter int unsigned SHIFT_STEP = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [3:0]            in_op,
  input  logic [XLEN-1:0]       in_a,
  input  logic [XLEN-1:0]       in_b,
  input  logic [XLEN-1:0]       in_imm,
  input  logic                  in_b_is_imm,
  input  logic [REG_ADDR_W-1:0] in_rd,
  input  logic                  in_wr_en,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [XLEN-1:0]       out_result,
  output logic [REG_ADDR_W-1:0] out_rd,
  output logic                  out_wr_en,
  output logic                  out_illegal,
  output logic                  busy
);

  localparam int unsigned SHW  = $clog2(XLEN);
  // Step size widened by one bit so SHIFT_STEP == XLEN still compares correctly.
  localparam logic [SHW:0] STEP = (SHW+1)'(SHIFT_STEP);

  typedef enum logic [3:0] {
    OP_NONE = 4'd0,
    OP_ADD  = 4'd1,
    OP_SUB  = 4'd2,
    OP_AND  = 4'd3,
    OP_OR   = 4'd4,
    OP_XOR  = 4'd5,
    OP_SLT  = 4'd6,
    OP_SLTU = 4'd7,
    OP_SLL  = 4'd8,
    OP_SRL  = 4'd9,
    OP_SRA  = 4'd10
  } op_e;

  typedef enum logic {
    S_IDLE,
    S_SHIFT
  } state_e;

  state_e                state_q;
  op_e                   shift_op_q;
  logic [XLEN-1:0]       work_q;
  logic [SHW-1:0]        rem_q;
  logic [REG_ADDR_W-1:0] rd_q;
  logic                  wr_en_q;

  logic                  out_valid_q;
  logic [XLEN-1:0]       out_result_q;
  logic [REG_ADDR_W-1:0] out_rd_q;
  logic                  out_wr_en_q;
  logic                  out_illegal_q;

  logic [XLEN-1:0]       opb;
  logic [XLEN-1:0]       alu_res_d;
  logic                  is_shift;
  logic                  is_illegal;
  logic                  accept;
  logic                  step_last;
  logic [SHW-1:0]        step_amt;
  logic [SHW-1:0]        rem_d;
  logic [XLEN-1:0]       work_d;

  function automatic logic [XLEN-1:0] do_shift(input op_e op,
                                               input logic [XLEN-1:0] v,
                                               input logic [SHW-1:0] amt);
    case (op)
      OP_SLL:  return v << amt;
      OP_SRA:  return XLEN'($signed(v) >>> amt);
      default: return v >> amt;
    endcase
  endfunction

  assign in_ready = !reset && !flush && (state_q == S_IDLE) &&
                    (!out_valid_q || out_ready);
  assign accept   = in_valid && in_ready;
  assign busy     = (state_q == S_SHIFT);

  assign out_valid   = out_valid_q;
  assign out_result  = out_result_q;
  assign out_rd      = out_rd_q;
  assign out_wr_en   = out_wr_en_q;
  assign out_illegal = out_illegal_q;

  // Operand select, op classification and single-cycle ALU result.
  always_comb begin
    opb        = in_b_is_imm ? in_imm : in_b;
    is_shift   = (in_op == OP_SLL) || (in_op == OP_SRL) || (in_op == OP_SRA);
    is_illegal = (in_op > OP_SRA);
    alu_res_d  = '0;
    case (op_e'(in_op))
      OP_ADD:  alu_res_d = in_a + opb;
      OP_SUB:  alu_res_d = in_a - opb;
      OP_AND:  alu_res_d = in_a & opb;
      OP_OR:   alu_res_d = in_a | opb;
      OP_XOR:  alu_res_d = in_a ^ opb;
      OP_SLT:  alu_res_d = XLEN'($signed(in_a) < $signed(opb));
      OP_SLTU: alu_res_d = XLEN'(in_a < opb);
      default: alu_res_d = '0;
    endcase
  end

  // One iterative shift step: a full SHIFT_STEP, or the remainder on the last step.
  always_comb begin
    step_last = ({1'b0, rem_q} <= STEP);
    step_amt  = step_last ? rem_q : SHW'(SHIFT_STEP);
    rem_d     = rem_q - step_amt;
    work_d    = do_shift(shift_op_q, work_q, step_amt);
  end

  // FSM, shifter state and output register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= S_IDLE;
      shift_op_q    <= OP_NONE;
      work_q        <= '0;
      rem_q         <= '0;
      rd_q          <= '0;
      wr_en_q       <= 1'b0;
      out_valid_q   <= 1'b0;
      out_result_q  <= '0;
      out_rd_q      <= '0;
      out_wr_en_q   <= 1'b0;
      out_illegal_q <= 1'b0;
    end else if (flush) begin
      state_q       <= S_IDLE;
      rem_q         <= '0;
      out_valid_q   <= 1'b0;
      out_result_q  <= '0;
      out_rd_q      <= '0;
      out_wr_en_q   <= 1'b0;
      out_illegal_q <= 1'b0;
    end else begin
      // Drain first; a load below in the same cycle overrides it.
      if (out_valid_q && out_ready) begin
        out_valid_q <= 1'b0;
      end
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            if (is_shift) begin
              shift_op_q <= op_e'(in_op);
              work_q     <= in_a;
              rem_q      <= opb[SHW-1:0];
              rd_q       <= in_rd;
              wr_en_q    <= in_wr_en;
              state_q    <= S_SHIFT;
            end else if (in_op != OP_NONE) begin
              out_valid_q   <= 1'b1;
              out_result_q  <= alu_res_d;
              out_rd_q      <= in_rd;
              out_wr_en_q   <= in_wr_en && !is_illegal;
              out_illegal_q <= is_illegal;
            end
          end
        end
        S_SHIFT: begin
          if (step_last) begin
            out_valid_q   <= 1'b1;
            out_result_q  <= work_d;
            out_rd_q      <= rd_q;
            out_wr_en_q   <= wr_en_q;
            out_illegal_q <= 1'b0;
            rem_q         <= '0;
            state_q       <= S_IDLE;
          end else begin
            work_q <= work_d;
            rem_q  <= rem_d;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_exec_stage.sv
// Testbench for alu_exec_stage: directed scenarios plus randomized traffic,
// all checked against a transaction-level reference model and scoreboard.
module tb_alu_exec_stage;

  logic        clk = 1'b0;
  logic        reset, flush, in_valid, in_ready, in_b_is_imm, in_wr_en;
  logic        out_valid, out_ready, out_wr_en, out_illegal, busy;
  logic [3:0]  in_op;
  logic [31:0] in_a, in_b, in_imm, out_result;
  logic [4:0]  in_rd, out_rd;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  int unsigned edge_cnt = 0;
  bit          rnd_on   = 1'b0;

  typedef struct {
    logic [31:0] res;
    logic [4:0]  rd;
    logic        wr;
    logic        ill;
    int unsigned due;
  } exp_t;

  exp_t        q[$];
  bit          sh_act   = 1'b0;
  int unsigned sh_start = 0;
  int unsigned sh_due   = 0;

  alu_exec_stage #(
    .XLEN(32),
    .REG_ADDR_W(5),
    .SHIFT_STEP(8)
  ) dut (
    .clk(clk),
    .reset(reset),
    .flush(flush),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_op(in_op),
    .in_a(in_a),
    .in_b(in_b),
    .in_imm(in_imm),
    .in_b_is_imm(in_b_is_imm),
    .in_rd(in_rd),
    .in_wr_en(in_wr_en),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_result(out_result),
    .out_rd(out_rd),
    .out_wr_en(out_wr_en),
    .out_illegal(out_illegal),
    .busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) edge_cnt++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: per-cycle expectations derived from accepted transactions.
  always @(negedge clk) begin
    bit          ov_exp, bz_exp, ir_exp;
    exp_t        e;
    logic [31:0] bb;
    logic [4:0]  sh;
    int unsigned lat;
    if (reset) begin
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_out_result", out_result, 32'd0);
      check("rst_out_rd", 32'(out_rd), 32'd0);
      check("rst_out_wr_en", 32'(out_wr_en), 32'd0);
      check("rst_out_illegal", 32'(out_illegal), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_in_ready", 32'(in_ready), 32'd0);
      q.delete();
      sh_act = 1'b0;
    end else begin
      ov_exp = (q.size() > 0) && (edge_cnt >= q[0].due);
      bz_exp = sh_act && (edge_cnt >= sh_start) && (edge_cnt < sh_due);
      ir_exp = !flush && !bz_exp && !(ov_exp && !out_ready);
      check("out_valid", 32'(out_valid), 32'(ov_exp));
      check("busy", 32'(busy), 32'(bz_exp));
      check("in_ready", 32'(in_ready), 32'(ir_exp));
      if (ov_exp && out_valid) begin
        check("result", out_result, q[0].res);
        check("rd", 32'(out_rd), 32'(q[0].rd));
        check("wr_en", 32'(out_wr_en), 32'(q[0].wr));
        check("illegal", 32'(out_illegal), 32'(q[0].ill));
      end
      if (flush) begin
        q.delete();
        sh_act = 1'b0;
      end else begin
        if (ov_exp && out_ready) void'(q.pop_front());
        if (in_valid && ir_exp && in_op != 4'd0) begin
          bb    = in_b_is_imm ? in_imm : in_b;
          sh    = bb[4:0];
          e.rd  = in_rd;
          e.wr  = in_wr_en;
          e.ill = 1'b0;
          e.due = edge_cnt + 1;
          case (in_op)
            4'd1:    e.res = in_a + bb;
            4'd2:    e.res = in_a - bb;
            4'd3:    e.res = in_a & bb;
            4'd4:    e.res = in_a | bb;
            4'd5:    e.res = in_a ^ bb;
            4'd6:    e.res = ($signed(in_a) < $signed(bb)) ? 32'd1 : 32'd0;
            4'd7:    e.res = (in_a < bb) ? 32'd1 : 32'd0;
            4'd8:    e.res = in_a << sh;
            4'd9:    e.res = in_a >> sh;
            4'd10:   e.res = $signed(in_a) >>> sh;
            default: begin e.res = 32'd0; e.ill = 1'b1; e.wr = 1'b0; end
          endcase
          if (in_op inside {4'd8, 4'd9, 4'd10}) begin
            lat      = (sh == 5'd0) ? 1 : (32'(sh) + 7) / 8;
            e.due    = edge_cnt + 1 + lat;
            sh_act   = 1'b1;
            sh_start = edge_cnt + 1;
            sh_due   = e.due;
          end
          q.push_back(e);
        end
      end
    end
  end

  // Random backpressure and occasional flush during the random phase.
  always @(posedge clk) begin
    if (rnd_on) begin
      #1;
      out_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 39) == 0);
    end
  end

  task automatic send(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] imm, input logic bimm, input logic [4:0] rd,
                      input logic wr, output int unsigned tries);
    bit acc;
    tries       = 0;
    in_valid    = 1'b1;
    in_op       = op;
    in_a        = a;
    in_b        = b;
    in_imm      = imm;
    in_b_is_imm = bimm;
    in_rd       = rd;
    in_wr_en    = wr;
    do begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      tries++;
    end while (!acc && tries < 200);
    check("send_accepted", 32'(acc), 32'd1);
    in_valid = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, %0d checks, %0d errors", n_checks, n_errors);
    $fatal(1);
  end

  initial begin
    int unsigned t, c;
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_op = '0; in_a = '0; in_b = '0;
    in_imm = '0; in_b_is_imm = 1'b0; in_rd = '0; in_wr_en = 1'b0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("ready_after_reset", 32'(in_ready), 32'd1);
    @(posedge clk); #1;

    // ADD wrap-around via immediate
    send(4'd1, 32'hFFFF_FFFF, 32'h0, 32'd1, 1'b1, 5'd5, 1'b1, t);
    @(negedge clk);
    check("add_valid", 32'(out_valid), 32'd1);
    check("add_result", out_result, 32'd0);
    check("add_rd", 32'(out_rd), 32'd5);
    check("add_wr_en", 32'(out_wr_en), 32'd1);
    @(posedge clk); #1;

    // SUB / SLT / SLTU back-to-back
    send(4'd2, 32'd1, 32'hFFFF_FFFF, 32'h0, 1'b0, 5'd1, 1'b1, t);
    send(4'd6, 32'd1, 32'hFFFF_FFFF, 32'h0, 1'b0, 5'd2, 1'b1, t);
    check("b2b_slt_tries", t, 1);
    send(4'd7, 32'd1, 32'hFFFF_FFFF, 32'h0, 1'b0, 5'd3, 1'b1, t);
    check("b2b_sltu_tries", t, 1);
    @(negedge clk);
    check("sltu_result", out_result, 32'd1);
    @(posedge clk); #1;

    // SRA by 20: three shift cycles
    send(4'd10, 32'h8000_0000, 32'd20, 32'h0, 1'b0, 5'd7, 1'b1, t);
    c = 0;
    @(negedge clk);
    while (!out_valid && c < 20) begin
      check("sra_in_ready_low", 32'(in_ready), 32'd0);
      c++;
      @(negedge clk);
    end
    check("sra_latency", c, 3);
    check("sra_result", out_result, 32'hFFFF_F800);
    @(posedge clk); #1;

    // SLL by 0: result one edge after accept
    send(4'd8, 32'h1234_5678, 32'h0, 32'd0, 1'b1, 5'd8, 1'b1, t);
    c = 0;
    @(negedge clk);
    while (!out_valid && c < 20) begin
      c++;
      @(negedge clk);
    end
    check("sll0_latency", c, 1);
    check("sll0_result", out_result, 32'h1234_5678);
    @(posedge clk); #1;

    // Backpressure, then drain and load in the same edge
    out_ready = 1'b0;
    send(4'd1, 32'd3, 32'd4, 32'h0, 1'b0, 5'd9, 1'b1, t);
    repeat (5) begin
      @(negedge clk);
      check("bp_in_ready", 32'(in_ready), 32'd0);
      check("bp_valid", 32'(out_valid), 32'd1);
      check("bp_result", out_result, 32'd7);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    send(4'd1, 32'd10, 32'd20, 32'h0, 1'b0, 5'd10, 1'b1, t);
    check("bp_swap_tries", t, 1);
    @(negedge clk);
    check("bp_new_result", out_result, 32'd30);
    check("bp_new_rd", 32'(out_rd), 32'd10);
    @(posedge clk); #1;

    // Illegal opcode
    send(4'd13, 32'hDEAD_BEEF, 32'd5, 32'h0, 1'b0, 5'd3, 1'b1, t);
    @(negedge clk);
    check("ill_flag", 32'(out_illegal), 32'd1);
    check("ill_wr_en", 32'(out_wr_en), 32'd0);
    check("ill_result", out_result, 32'd0);
    check("ill_rd", 32'(out_rd), 32'd3);
    @(posedge clk); #1;

    // Leave a non-zero result in the output register, then reset mid-shift
    send(4'd1, 32'd5, 32'd6, 32'h0, 1'b0, 5'd4, 1'b1, t);
    @(posedge clk); #1;
    send(4'd9, 32'hF0F0_F0F0, 32'd31, 32'h0, 1'b0, 5'd6, 1'b1, t);
    @(posedge clk);
    #3 reset = 1'b1;
    #1;
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_valid", 32'(out_valid), 32'd0);
    check("arst_result", out_result, 32'd0);
    check("arst_rd", 32'(out_rd), 32'd0);
    check("arst_wr_en", 32'(out_wr_en), 32'd0);
    check("arst_in_ready", 32'(in_ready), 32'd0);
    @(posedge clk); @(posedge clk);
    #1 reset = 1'b0;
    repeat (8) begin
      @(negedge clk);
      check("arst_no_stale", 32'(out_valid), 32'd0);
    end
    @(posedge clk); #1;

    // Flush on the second shift cycle of shamt=31
    send(4'd9, 32'hFFFF_FFFF, 32'd31, 32'h0, 1'b0, 5'd11, 1'b1, t);
    @(posedge clk); #1 flush = 1'b1;
    @(posedge clk); #1 flush = 1'b0;
    @(negedge clk);
    check("flush_valid", 32'(out_valid), 32'd0);
    check("flush_busy", 32'(busy), 32'd0);
    check("flush_in_ready", 32'(in_ready), 32'd1);
    check("flush_result", out_result, 32'd0);
    repeat (6) begin
      @(negedge clk);
      check("flush_no_result", 32'(out_valid), 32'd0);
    end
    @(posedge clk); #1;

    // Randomized traffic with backpressure and occasional flush
    rnd_on = 1'b1;
    for (int i = 0; i < 400; i++) begin
      send(4'($urandom_range(0, 15)), $urandom, $urandom, $urandom,
           1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
           1'($urandom_range(0, 1)), t);
    end
    rnd_on = 1'b0;
    @(posedge clk);
    #2;
    flush     = 1'b0;
    out_ready = 1'b1;
    repeat (40) @(posedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
